// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty/mode/polarity/enable, double-buffered parameters.
// Latency: pwm and period_end are registered, one cycle after the counter slot they represent; enable acts one cycle later.
// Backpressure: none; update_parameters is a one-cycle strobe always accepted, the last strobe before the period end wins.
module pwm_multichannel #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 8,
    parameter int INITIAL_PERIOD = 255,
    parameter int INITIAL_DUTY   = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      update_parameters,
    input  logic [WIDTH-1:0]          pwm_period,
    input  logic [CHANNELS*WIDTH-1:0] pwm_duty,
    input  logic [CHANNELS-1:0]       center_mode,
    input  logic [CHANNELS-1:0]       invert,
    input  logic [CHANNELS-1:0]       channel_enable,
    output logic                      update_pending,
    output logic                      period_end,
    output logic [CHANNELS-1:0]       pwm
);

    localparam logic [WIDTH-1:0] INIT_P = WIDTH'(INITIAL_PERIOD);
    localparam logic [WIDTH-1:0] INIT_D = WIDTH'(INITIAL_DUTY);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    // Active parameter set (governs the running period) and shadow set (waits for the commit point)
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]          per_q, per_d;
    logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
    logic [CHANNELS-1:0]       cm_q, cm_d;
    logic [CHANNELS-1:0]       inv_q, inv_d;
    logic [WIDTH-1:0]          sh_per_q, sh_per_d;
    logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [CHANNELS-1:0]       sh_cm_q, sh_cm_d;
    logic [CHANNELS-1:0]       sh_inv_q, sh_inv_d;
    logic                      pend_q, pend_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      pe_q, pe_d;

    logic                      last_slot;
    logic [WIDTH-1:0]          deff  [CHANNELS];
    logic [WIDTH-1:0]          start [CHANNELS];
    logic [CHANNELS-1:0]       act;

    assign last_slot = (cnt_q == per_q - ONE);

    // Counter wrap, shadow capture and commit at the last slot of the period
    always_comb begin
        cnt_d     = last_slot ? '0 : cnt_q + ONE;
        per_d     = per_q;
        duty_d    = duty_q;
        cm_d      = cm_q;
        inv_d     = inv_q;
        sh_per_d  = sh_per_q;
        sh_duty_d = sh_duty_q;
        sh_cm_d   = sh_cm_q;
        sh_inv_d  = sh_inv_q;
        pend_d    = pend_q;
        if (update_parameters) begin
            sh_per_d  = pwm_period;
            sh_duty_d = pwm_duty;
            sh_cm_d   = center_mode;
            sh_inv_d  = invert;
            pend_d    = 1'b1;
        end
        if (last_slot) begin
            // A strobe on the commit cycle bypasses the shadow so it is not delayed a whole period
            if (update_parameters) begin
                per_d  = (pwm_period == '0) ? ONE : pwm_period;
                duty_d = pwm_duty;
                cm_d   = center_mode;
                inv_d  = invert;
                pend_d = 1'b0;
            end else if (pend_q) begin
                per_d  = (sh_per_q == '0) ? ONE : sh_per_q;
                duty_d = sh_duty_q;
                cm_d   = sh_cm_q;
                inv_d  = sh_inv_q;
                pend_d = 1'b0;
            end
        end
    end

    // Per-channel compare: clamp duty to the period, then edge or centered window
    always_comb begin
        pwm_d = '0;
        act   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            deff[i]  = (duty_q[i*WIDTH +: WIDTH] > per_q) ? per_q : duty_q[i*WIDTH +: WIDTH];
            // start + deff never exceeds per_q, so the WIDTH-bit sum cannot wrap
            start[i] = (per_q - deff[i]) >> 1;
            if (cm_q[i])
                act[i] = (cnt_q >= start[i]) && (cnt_q < start[i] + deff[i]);
            else
                act[i] = (cnt_q < deff[i]);
            pwm_d[i] = channel_enable[i] ? (act[i] ^ inv_q[i]) : inv_q[i];
        end
        pe_d = last_slot;
    end

    // State registers; reset also discards any pending shadow update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            per_q     <= INIT_P;
            duty_q    <= {CHANNELS{INIT_D}};
            cm_q      <= '0;
            inv_q     <= '0;
            sh_per_q  <= INIT_P;
            sh_duty_q <= {CHANNELS{INIT_D}};
            sh_cm_q   <= '0;
            sh_inv_q  <= '0;
            pend_q    <= 1'b0;
            pwm_q     <= '0;
            pe_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            duty_q    <= duty_d;
            cm_q      <= cm_d;
            inv_q     <= inv_d;
            sh_per_q  <= sh_per_d;
            sh_duty_q <= sh_duty_d;
            sh_cm_q   <= sh_cm_d;
            sh_inv_q  <= sh_inv_d;
            pend_q    <= pend_d;
            pwm_q     <= pwm_d;
            pe_q      <= pe_d;
        end
    end

    assign update_pending = pend_q;
    assign period_end     = pe_q;
    assign pwm            = pwm_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel with hand-computed slot/edge expectations.
// edge_n counts rising edges since reset release; after edge e, pwm shows counter slot e-1 (mod P).
// No backpressure involved; every wait is a bounded number of clock edges.
module tb_pwm_multichannel;

    logic        clk;
    logic        reset;
    logic        update_parameters;
    logic [7:0]  pwm_period;
    logic [31:0] pwm_duty;
    logic [3:0]  center_mode;
    logic [3:0]  invert;
    logic [3:0]  channel_enable;
    logic        update_pending;
    logic        period_end;
    logic [3:0]  pwm;

    int vec_n;
    int err_n;
    int edge_n;
    int ones;

    pwm_multichannel #(
        .CHANNELS(4), .WIDTH(8), .INITIAL_PERIOD(255), .INITIAL_DUTY(128)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .update_parameters (update_parameters),
        .pwm_period        (pwm_period),
        .pwm_duty          (pwm_duty),
        .center_mode       (center_mode),
        .invert            (invert),
        .channel_enable    (channel_enable),
        .update_pending    (update_pending),
        .period_end        (period_end),
        .pwm               (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic goto(input int target);
        while (edge_n < target) tick();
    endtask

    // Count ones on one channel over edges edge_n+1 .. target
    task automatic count_ones(input int target, input int ch, output int n);
        n = 0;
        while (edge_n < target) begin
            tick();
            if (pwm[ch]) n++;
        end
    endtask

    task automatic strobe_on();
        update_parameters = 1'b1;
    endtask

    initial begin
        vec_n = 0; err_n = 0; edge_n = 0;
        reset = 1'b1;
        update_parameters = 1'b0;
        pwm_period = 8'd255;
        pwm_duty = {4{8'd128}};
        center_mode = 4'b0000;
        invert = 4'b0000;
        channel_enable = 4'b1111;
        #1 reset = 1'b0;
        #1;
        chk("rst_pwm", 32'(pwm), 32'h0);
        chk("rst_pe", 32'(period_end), 32'h0);
        chk("rst_pend", 32'(update_pending), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        edge_n = 0;

        // Defaults: P=255, D=128 edge-aligned
        goto(1);   chk("def_first", 32'(pwm), 32'hF);
        goto(128); chk("def_last_hi", 32'(pwm), 32'hF);
        goto(129); chk("def_first_lo", 32'(pwm), 32'h0);
        goto(254); chk("def_pe_early", 32'(period_end), 32'h0);
        goto(255); chk("def_pe", 32'(period_end), 32'h1);
                   chk("def_pe_lo", 32'(pwm), 32'h0);
        goto(256); chk("def_wrap", 32'(pwm), 32'hF);

        // Mid-period update at cnt=10: period 10, ch0 duty 3 centered
        goto(265);
        pwm_period = 8'd10;
        pwm_duty[0 +: 8] = 8'd3;
        center_mode[0] = 1'b1;
        strobe_on();
        tick();
        update_parameters = 1'b0;
        chk("mid_pend", 32'(update_pending), 32'h1);
        goto(509); chk("mid_pend_hold", 32'(update_pending), 32'h1);
        goto(510); chk("mid_commit_pend", 32'(update_pending), 32'h0);
                   chk("mid_old_pe", 32'(period_end), 32'h1);
        goto(511); chk("mid_ch1_clamp", 32'(pwm[1]), 32'h1);
        goto(513); chk("mid_ch0_s2", 32'(pwm[0]), 32'h0);
        goto(514); chk("mid_ch0_s3", 32'(pwm[0]), 32'h1);
        goto(516); chk("mid_ch0_s5", 32'(pwm[0]), 32'h1);
        goto(517); chk("mid_ch0_s6", 32'(pwm[0]), 32'h0);
        goto(519); chk("p10_pe_early", 32'(period_end), 32'h0);

        // Strobe exactly on the commit cycle: ch1 duty 0
        pwm_duty[8 +: 8] = 8'd0;
        strobe_on();
        tick();
        update_parameters = 1'b0;
        chk("cc_pe", 32'(period_end), 32'h1);
        chk("cc_pend", 32'(update_pending), 32'h0);
        count_ones(530, 1, ones);
        chk("cc_ch1_ones", 32'(ones), 32'd0);

        // Clamp + polarity: period 6, ch2 duty 9 inverted
        goto(531);
        pwm_period = 8'd6;
        pwm_duty[16 +: 8] = 8'd9;
        invert[2] = 1'b1;
        strobe_on();
        tick();
        update_parameters = 1'b0;
        goto(540); chk("cl_ch2_old", 32'(pwm[2]), 32'h1);
        goto(541); chk("cl_vec_s0", 32'(pwm), 32'h8);
        edge_n = 540;
        edge_n = 541;
        count_ones(546, 2, ones);
        chk("cl_ch2_ones", 32'(ones), 32'd0);
        goto(547);
        chk("en_before", 32'(pwm[2]), 32'h0);
        channel_enable[2] = 1'b0;
        tick();
        chk("en_after", 32'(pwm[2]), 32'h1);

        // Back-to-back strobes on ch3: 2 then 5, last wins
        pwm_duty[24 +: 8] = 8'd2;
        strobe_on();
        tick();
        update_parameters = 1'b0;
        chk("bb_pend1", 32'(update_pending), 32'h1);
        goto(550);
        pwm_duty[24 +: 8] = 8'd5;
        strobe_on();
        tick();
        update_parameters = 1'b0;
        goto(552); chk("bb_commit", 32'(update_pending), 32'h0);
        count_ones(558, 3, ones);
        chk("bb_ch3_ones", 32'(ones), 32'd5);
        chk("bb_ch3_s5", 32'(pwm[3]), 32'h0);

        // Async reset with a pending period-20 update
        goto(560);
        pwm_period = 8'd20;
        strobe_on();
        tick();
        update_parameters = 1'b0;
        chk("ar_pend", 32'(update_pending), 32'h1);
        chk("ar_vec", 32'(pwm), 32'hD);
        #2 reset = 1'b0;
        #1;
        chk("ar_pwm", 32'(pwm), 32'h0);
        chk("ar_pe", 32'(period_end), 32'h0);
        chk("ar_pend0", 32'(update_pending), 32'h0);
        channel_enable = 4'b1111;
        repeat (3) @(posedge clk);
        #1 chk("ar_hold", 32'(pwm), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        edge_n = 0;
        goto(1);   chk("rr_first", 32'(pwm), 32'hF);
        goto(128); chk("rr_last_hi", 32'(pwm), 32'hF);
        goto(129); chk("rr_first_lo", 32'(pwm), 32'h0);
        goto(255); chk("rr_pe", 32'(period_end), 32'h1);
        goto(275); chk("rr_no_p20", 32'(period_end), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
